// File: rtl/solver_pkg.sv
// Shared types and geometry for the solver grid and its init/readback helpers.
// The grid is 6x6 patches of 4x4 nodes; index math elsewhere assumes these values.
package solver_pkg;

    localparam int PATCH_NUM_DIMENSION = 6;
    localparam int PATCH_SIZE          = 4;
    localparam int DATA_WIDTH          = 18;
    localparam int GRID_DIM            = PATCH_NUM_DIMENSION * PATCH_SIZE;
    localparam int NODE_TOTAL          = GRID_DIM * GRID_DIM;

    localparam int PIDX_W  = 6;
    localparam int NIDX_W  = 4;
    localparam int CNT_W   = 10;
    localparam int COORD_W = 5;

    localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(GRID_DIM - 1);

    typedef logic signed [DATA_WIDTH-1:0] node_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ARM  = 2'd2,
        RUN  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/raster_to_patch.sv
// Combinational raster (row, col) to (patch, node) mapping for the 24x24 grid.
// Shift-and-add only so it can be shared with a future readback block.
module raster_to_patch
    import solver_pkg::*;
(
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    output logic [PIDX_W-1:0]  patch_o,
    output logic [NIDX_W-1:0]  node_o
);

    logic [PIDX_W-1:0] prow;
    logic [PIDX_W-1:0] pcol;

    assign prow = {3'b000, row_i[4:2]};
    assign pcol = {3'b000, col_i[4:2]};

    // prow*6 + pcol
    assign patch_o = (prow << 2) + (prow << 1) + pcol;
    assign node_o  = {row_i[1:0], col_i[1:0]};

endmodule

// File: rtl/patch_init_loader.sv
// Streams a raster-order initial displacement profile into the grid's init
// storage, then arms the solver. All outputs are registered.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both high and load_start is low; in_data must be stable while in_valid.
module patch_init_loader
    import solver_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [PIDX_W-1:0]     wr_patch,
    output logic [NIDX_W-1:0]     wr_node,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  init_done,
    output logic                  solver_enable,
    output logic                  busy,
    output logic [1:0]            dbg_state
);

    loader_state_t       state_q;
    logic [COORD_W-1:0]  row_q;
    logic [COORD_W-1:0]  col_q;
    logic                in_ready_q;
    logic                wr_en_q;
    logic [PIDX_W-1:0]   wr_patch_q;
    logic [NIDX_W-1:0]   wr_node_q;
    node_t               wr_data_q;
    logic                init_done_q;
    logic                solver_enable_q;
    logic                busy_q;

    logic [PIDX_W-1:0]   patch_d;
    logic [NIDX_W-1:0]   node_d;

    raster_to_patch u_map (
        .row_i   (row_q),
        .col_i   (col_q),
        .patch_o (patch_d),
        .node_o  (node_d)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            row_q           <= '0;
            col_q           <= '0;
            in_ready_q      <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_patch_q      <= '0;
            wr_node_q       <= '0;
            wr_data_q       <= '0;
            init_done_q     <= 1'b0;
            solver_enable_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            wr_en_q     <= 1'b0;
            init_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_q    <= LOAD;
                        row_q      <= '0;
                        col_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        row_q <= '0;
                        col_q <= '0;
                    end else if (in_valid && in_ready_q) begin
                        wr_en_q    <= 1'b1;
                        wr_patch_q <= patch_d;
                        wr_node_q  <= node_d;
                        wr_data_q  <= node_t'(in_data);
                        if (col_q == LAST_COORD) begin
                            col_q <= '0;
                            if (row_q == LAST_COORD) begin
                                // Dropping ready on this edge blocks a 577th beat.
                                row_q      <= '0;
                                state_q    <= ARM;
                                in_ready_q <= 1'b0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                ARM: begin
                    state_q         <= RUN;
                    init_done_q     <= 1'b1;
                    solver_enable_q <= 1'b1;
                    busy_q          <= 1'b0;
                end
                RUN: begin
                    if (load_start) begin
                        // Freeze the solver before the first new write lands.
                        state_q         <= LOAD;
                        row_q           <= '0;
                        col_q           <= '0;
                        in_ready_q      <= 1'b1;
                        busy_q          <= 1'b1;
                        solver_enable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_q;
    assign wr_en         = wr_en_q;
    assign wr_patch      = wr_patch_q;
    assign wr_node       = wr_node_q;
    assign wr_data       = wr_data_q;
    assign init_done     = init_done_q;
    assign solver_enable = solver_enable_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_patch_init_loader.sv
// Self-checking bench for patch_init_loader: scenario tasks drive the stream,
// a negedge monitor pops a queue of expected (patch, node, data) writes.
module tb_patch_init_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic        in_valid;
    logic [17:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_patch;
    logic [3:0]  wr_node;
    logic [17:0] wr_data;
    logic        init_done;
    logic        solver_enable;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    logic [27:0] exp_q[$];
    logic [27:0] wr_log[$];
    logic [27:0] exp_w;

    patch_init_loader dut (
        .clock         (clk),
        .reset         (rst_n),
        .load_start    (load_start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .wr_en         (wr_en),
        .wr_patch      (wr_patch),
        .wr_node       (wr_node),
        .wr_data       (wr_data),
        .init_done     (init_done),
        .solver_enable (solver_enable),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference mapping written with division/modulo, independent of the RTL shifts.
    function automatic logic [27:0] exp_word(input int beat, input logic [17:0] d);
        int r, c, p, nd;
        r  = beat / 24;
        c  = beat % 24;
        p  = (r / 4) * 6 + (c / 4);
        nd = (r % 4) * 4 + (c % 4);
        return {6'(p), 4'(nd), d};
    endfunction

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cnt++;
            wr_log.push_back({wr_patch, wr_node, wr_data});
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected patch=%0d node=%0d data=%h required no write",
                         wr_patch, wr_node, wr_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_patch, wr_node, wr_data} !== exp_w) begin
                    failures++;
                    $display("FAIL wr_seq patch=%0d node=%0d data=%h required patch=%0d node=%0d data=%h",
                             wr_patch, wr_node, wr_data, exp_w[27:22], exp_w[21:18], exp_w[17:0]);
                end
            end
        end
        if (init_done === 1'b1) done_cnt++;
    end

    task automatic pulse_start(input bit with_valid);
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = with_valid;
        in_data    = 18'h2AAAA;
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the last accepting edge.
    task automatic drive_stream(input int n, input bit stall, input bit use_const,
                                input logic [17:0] cval);
        int sent = 0;
        int t    = 0;
        while (sent < n && t < 4 * n + 50) begin
            if (stall && (t % 3 == 2)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = use_const ? cval : 18'(sent);
                if (in_ready === 1'b1) begin
                    exp_q.push_back(exp_word(sent, in_data));
                    sent++;
                end
            end
            t++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (sent != n) begin
            failures++;
            $display("FAIL stream_timeout accepted=%0d required=%0d", sent, n);
        end
    endtask

    task automatic check_finish(input string tag, input int done_base);
        checks++;
        if (init_done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL %s_arm init_done=%b busy=%b in_ready=%b state=%0d required 0 1 0 2",
                     tag, init_done, busy, in_ready, dbg_state);
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || solver_enable !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd3) begin
            failures++;
            $display("FAIL %s_done init_done=%b solver_enable=%b busy=%b state=%0d required 1 1 0 3",
                     tag, init_done, solver_enable, busy, dbg_state);
        end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b0 || solver_enable !== 1'b1) begin
            failures++;
            $display("FAIL %s_run init_done=%b solver_enable=%b required 0 1",
                     tag, init_done, solver_enable);
        end
        checks++;
        if (done_cnt - done_base != 1) begin
            failures++;
            $display("FAIL %s_done_count got=%0d required=1", tag, done_cnt - done_base);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got=%0d required=0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        int wbase;
        rst_n      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, wr_en, wr_patch, wr_node, wr_data, init_done, solver_enable, busy, dbg_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs in_ready=%b wr_en=%b patch=%0d node=%0d data=%h done=%b en=%b busy=%b state=%0d required all 0",
                     in_ready, wr_en, wr_patch, wr_node, wr_data, init_done, solver_enable, busy, dbg_state);
        end
        rst_n = 1'b1;
        wbase = wr_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if ({in_ready, wr_en, init_done, solver_enable, busy, dbg_state} !== '0) begin
            failures++;
            $display("FAIL idle_outputs in_ready=%b wr_en=%b done=%b en=%b busy=%b state=%0d required all 0",
                     in_ready, wr_en, init_done, solver_enable, busy, dbg_state);
        end
        in_valid = 1'b1;
        in_data  = 18'h00123;
        repeat (5) begin
            @(negedge clk);
            if (in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0 || wr_cnt != wbase) begin
            failures++;
            $display("FAIL idle_valid in_ready_high=%0d writes=%0d required 0 0", bad, wr_cnt - wbase);
        end
    endtask

    task automatic test_full_load();
        int wbase = wr_cnt;
        int lbase = wr_log.size();
        int dbase = done_cnt;
        pulse_start(1'b0);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1 || solver_enable !== 1'b0 || dbg_state !== 2'd1) begin
            failures++;
            $display("FAIL load_entry in_ready=%b busy=%b en=%b state=%0d required 1 1 0 1",
                     in_ready, busy, solver_enable, dbg_state);
        end
        drive_stream(576, 1'b0, 1'b0, 18'h0);
        check_finish("full", dbase);
        checks++;
        if (wr_cnt - wbase != 576) begin
            failures++;
            $display("FAIL full_count got=%0d required=576", wr_cnt - wbase);
        end
        checks++;
        if (wr_log[lbase] !== {6'd0, 4'd0, 18'd0} || wr_log[lbase + 5] !== {6'd1, 4'd1, 18'd5}) begin
            failures++;
            $display("FAIL full_beat0_5 got=%h %h required=%h %h", wr_log[lbase], wr_log[lbase + 5],
                     {6'd0, 4'd0, 18'd0}, {6'd1, 4'd1, 18'd5});
        end
        checks++;
        if (wr_log[lbase + 100] !== {6'd7, 4'd0, 18'd100} || wr_log[lbase + 575] !== {6'd35, 4'd15, 18'd575}) begin
            failures++;
            $display("FAIL full_beat100_575 got=%h %h required=%h %h", wr_log[lbase + 100], wr_log[lbase + 575],
                     {6'd7, 4'd0, 18'd100}, {6'd35, 4'd15, 18'd575});
        end
    endtask

    task automatic test_stalled_stream();
        int wbase = wr_cnt;
        int dbase = done_cnt;
        pulse_start(1'b0);
        drive_stream(576, 1'b1, 1'b0, 18'h0);
        check_finish("stall", dbase);
        checks++;
        if (wr_cnt - wbase != 576) begin
            failures++;
            $display("FAIL stall_count got=%0d required=576", wr_cnt - wbase);
        end
    endtask

    task automatic test_restart();
        int wbase = wr_cnt;
        int lbase = wr_log.size();
        int dbase = done_cnt;
        pulse_start(1'b1);
        drive_stream(200, 1'b0, 1'b0, 18'h0);
        pulse_start(1'b1);
        drive_stream(576, 1'b0, 1'b1, 18'h3FFFF);
        check_finish("restart", dbase);
        checks++;
        if (wr_cnt - wbase != 776) begin
            failures++;
            $display("FAIL restart_count got=%0d required=776", wr_cnt - wbase);
        end
        checks++;
        if (wr_log[lbase + 199] !== {6'd13, 4'd3, 18'd199} || wr_log[lbase + 200] !== {6'd0, 4'd0, 18'h3FFFF}) begin
            failures++;
            $display("FAIL restart_first got=%h %h required=%h %h", wr_log[lbase + 199], wr_log[lbase + 200],
                     {6'd13, 4'd3, 18'd199}, {6'd0, 4'd0, 18'h3FFFF});
        end
    endtask

    task automatic test_reload_from_run();
        int wbase;
        int dbase = done_cnt;
        pulse_start(1'b0);
        checks++;
        if (solver_enable !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1 || wr_en !== 1'b0) begin
            failures++;
            $display("FAIL reload_entry en=%b in_ready=%b busy=%b wr_en=%b required 0 1 1 0",
                     solver_enable, in_ready, busy, wr_en);
        end
        wbase = wr_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_cnt != wbase) begin
            failures++;
            $display("FAIL reload_idle_writes got=%0d required=0", wr_cnt - wbase);
        end
        drive_stream(576, 1'b0, 1'b0, 18'h0);
        check_finish("reload", dbase);
    endtask

    task automatic test_async_reset();
        int wbase;
        int lbase;
        pulse_start(1'b0);
        drive_stream(300, 1'b0, 1'b0, 18'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, wr_en, wr_patch, wr_node, wr_data, init_done, solver_enable, busy, dbg_state} !== '0) begin
            failures++;
            $display("FAIL async_reset in_ready=%b wr_en=%b patch=%0d node=%0d data=%h done=%b en=%b busy=%b state=%0d required all 0",
                     in_ready, wr_en, wr_patch, wr_node, wr_data, init_done, solver_enable, busy, dbg_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dbg_state !== 2'd0 || in_ready !== 1'b0 || solver_enable !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL async_idle state=%0d in_ready=%b en=%b pending=%0d required 0 0 0 0",
                     dbg_state, in_ready, solver_enable, exp_q.size());
        end
        wbase = wr_cnt;
        lbase = wr_log.size();
        pulse_start(1'b0);
        drive_stream(24, 1'b0, 1'b0, 18'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_cnt - wbase != 24 || wr_log[lbase] !== {6'd0, 4'd0, 18'd0}) begin
            failures++;
            $display("FAIL async_restart writes=%0d first=%h required 24 %h",
                     wr_cnt - wbase, wr_log[lbase], {6'd0, 4'd0, 18'd0});
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_stalled_stream();
        test_restart();
        test_reload_from_run();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
